// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - control/status bundle for clk_div_gen; cyc_cnt present only with CLK_DIV_GEN_CYC_CNT_EN
interface clk_div_gen_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             div_ack;
    logic             clk_out;
    logic             rise_pulse;
    logic             locked;
    logic             cfg_err;
`ifdef CLK_DIV_GEN_CYC_CNT_EN
    logic [15:0]      cyc_cnt;
`endif

    modport master (
        output en, div_val, div_load,
`ifdef CLK_DIV_GEN_CYC_CNT_EN
        input  cyc_cnt,
`endif
        input  div_ack, clk_out, rise_pulse, locked, cfg_err
    );

    modport slave (
        input  en, div_val, div_load,
`ifdef CLK_DIV_GEN_CYC_CNT_EN
        output cyc_cnt,
`endif
        output div_ack, clk_out, rise_pulse, locked, cfg_err
    );
endinterface

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - glitch-free programmable clock divider; optional cycle counter under CLK_DIV_GEN_CYC_CNT_EN
module clk_div_gen #(
    parameter int DIV_W   = 8,
    parameter int RST_DIV = 2
) (
    input  logic         clk,
    input  logic         rst,
    clk_div_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
    localparam logic [DIV_W-1:0] RST_VAL = DIV_W'(RST_DIV);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_pulse_q, rise_pulse_d;
    logic             div_ack_q, div_ack_d;
    logic             locked_q, locked_d;
    logic             cfg_err_q, cfg_err_d;
    logic             load_ok;
    logic             wrap;
    logic             running;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        locked_d  = locked_q;
        cfg_err_d = cfg_err_q;
        div_ack_d = 1'b0;
        load_ok   = bus.div_load && (bus.div_val >= TWO);
        wrap      = (cnt_q == (ratio_q - ONE));

        if (bus.div_load) begin
            cfg_err_d = !load_ok;
        end

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                pend_d   = 1'b0;
                locked_d = 1'b0;
                if (load_ok) begin
                    ratio_d   = bus.div_val;
                    div_ack_d = 1'b1;
                end
                if (bus.en) begin
                    state_d = RUN;
                end
            end
            default: begin
                // A load landing on the boundary edge is applied at that same boundary.
                if (load_ok) begin
                    shadow_d = bus.div_val;
                    pend_d   = 1'b1;
                end
                if (wrap) begin
                    cnt_d = '0;
                    if (pend_d) begin
                        ratio_d   = shadow_d;
                        div_ack_d = 1'b1;
                        pend_d    = 1'b0;
                        locked_d  = 1'b0;
                    end else begin
                        locked_d = 1'b1;
                    end
                    state_d = bus.en ? RUN : IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (!bus.en || state_q == STOP) begin
                        state_d = STOP;
                    end else begin
                        state_d = pend_d ? PEND : RUN;
                    end
                end
                if (state_d == IDLE) begin
                    locked_d = 1'b0;
                end
            end
        endcase

        // Outputs are derived from next-cycle phase so they stay registered and aligned with cnt.
        running      = (state_d != IDLE);
        clk_out_d    = running && (cnt_d < (ratio_d - (ratio_d >> 1)));
        rise_pulse_d = running && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ratio_q      <= RST_VAL;
            shadow_q     <= '0;
            pend_q       <= 1'b0;
            clk_out_q    <= 1'b0;
            rise_pulse_q <= 1'b0;
            div_ack_q    <= 1'b0;
            locked_q     <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ratio_q      <= ratio_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            clk_out_q    <= clk_out_d;
            rise_pulse_q <= rise_pulse_d;
            div_ack_q    <= div_ack_d;
            locked_q     <= locked_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bus.clk_out    = clk_out_q;
    assign bus.rise_pulse = rise_pulse_q;
    assign bus.div_ack    = div_ack_q;
    assign bus.locked     = locked_q;
    assign bus.cfg_err    = cfg_err_q;

`ifdef CLK_DIV_GEN_CYC_CNT_EN
    logic [15:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q + {15'd0, rise_pulse_q};
        if (state_d == IDLE && state_q != IDLE) begin
            cyc_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign bus.cyc_cnt = cyc_cnt_q;
`endif
endmodule
